fast_square_tx_bb: RTL and testbench

Transmit-side counterpart of the fast-square receive baseband path. Accepts 16-bit packed 1-bit I/Q words from the host TX FIFO, detects the 0x8000 restart-marker preamble, then serialises each word MSB-first at one bit per clock into signed ±AMPLITUDE baseband samples for the TX DUC chain. Packing order matches the receive path: oldest bit in bit 15, newest in bit 0.

---
 rtl/fast_square_pkg.sv | 35 +++
 rtl/fast_square_word_fifo.sv | 69 ++++++
 rtl/fast_square_tx_bb.sv | 175 +++++++++++++++++
 tb/tb_fast_square_tx_bb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fast_square_pkg.sv
// fast_square_pkg: shared constants, types and helpers for the fast-square
// baseband blocks.
//   MARKER_WORD       restart-marker preamble value on both I and Q
//   DEFAULT_AMPLITUDE default baseband magnitude for one bit
//   tx_state_t        transmit state encoding (IDLE, SYNC, RUN)
//   iq_word_t         one packed I/Q word as stored in the TX FIFO
package fast_square_pkg;

    localparam int unsigned WORD_W = 16;
    localparam logic [WORD_W-1:0] MARKER_WORD = 16'h8000;
    localparam logic signed [15:0] DEFAULT_AMPLITUDE = 16'sd8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] i;
        logic [WORD_W-1:0] q;
    } iq_word_t;

    // Map one bit to a signed NRZ level.
    function automatic logic signed [15:0] nrz_level(input logic b,
                                                     input logic signed [15:0] amp);
        return b ? amp : -amp;
    endfunction

    // Marker pair: both halves carry the preamble value.
    function automatic logic is_marker(input iq_word_t w);
        return (w.i == MARKER_WORD) && (w.q == MARKER_WORD);
    endfunction

endpackage

// File: rtl/fast_square_word_fifo.sv
// fast_square_word_fifo: synchronous single-clock word FIFO, no fall-through.
//   clock, reset  system clock, synchronous active-high reset
//   wr_en/wr_data write request (ignored while full)
//   rd_en/rd_data read request (ignored while empty); rd_data shows the head
//   full, empty   registered occupancy flags
module fast_square_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_wr;
    logic             do_rd;

    // Full is judged on the registered flag, so a write at full is dropped
    // even if a read happens in the same cycle.
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Occupancy after this cycle's transfers.
    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + CNT_W'(1);
        end else if (!do_wr && do_rd) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Pointers and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fast_square_tx_bb.sv
// fast_square_tx_bb: fast-square transmit baseband. Buffers packed 1-bit I/Q
// words, waits for MIN_MARKERS consecutive 0x8000/0x8000 marker words, then
// serialises each data word MSB-first, one bit per clock, as +/-AMPLITUDE.
//   clock, reset        system clock, synchronous active-high reset
//   enable              transmit enable; low forces IDLE
//   data_in_strobe      write i_in/q_in into the word FIFO
//   i_in, q_in          packed I/Q bits (oldest bit in bit 15)
//   fifo_full           FIFO holds FIFO_DEPTH words
//   data_req            one-cycle pulse the cycle after each FIFO pop
//   i_out, q_out        signed baseband samples
//   tx_active           high while samples are being emitted (RUN)
//   underrun, overflow  sticky error flags, cleared by reset only
// Build option: FAST_SQUARE_TX_SHAPE_EN averages the current and previous bit
// (half amplitude each) so every bit transition passes through zero.
module fast_square_tx_bb
    import fast_square_pkg::*;
#(
    parameter logic signed [15:0] AMPLITUDE   = DEFAULT_AMPLITUDE,
    parameter int unsigned        MIN_MARKERS = 8,
    parameter int unsigned        FIFO_DEPTH  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               data_in_strobe,
    input  logic [15:0]        i_in,
    input  logic [15:0]        q_in,
    output logic               fifo_full,
    output logic               data_req,
    output logic signed [15:0] i_out,
    output logic signed [15:0] q_out,
    output logic               tx_active,
    output logic               underrun,
    output logic               overflow
);

    localparam int unsigned PHASE_W = 4;
    localparam int unsigned MCNT_W  = $clog2(MIN_MARKERS + 1);
    localparam logic [MCNT_W-1:0] MCNT_MAX = MCNT_W'(MIN_MARKERS);

    tx_state_t          state;
    logic [PHASE_W-1:0] phase;
    logic [MCNT_W-1:0]  marker_cnt;
    logic [15:0]        i_sr;
    logic [15:0]        q_sr;

    logic [31:0]        fifo_rd;
    iq_word_t           fifo_word;
    logic               fifo_empty;
    logic               pop_c;
    logic               pop_marker_c;
    logic               load_c;
    logic               i_bit_c;
    logic               q_bit_c;
    logic signed [15:0] i_level_c;
    logic signed [15:0] q_level_c;

    fast_square_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (data_in_strobe),
        .wr_data ({i_in, q_in}),
        .rd_en   (pop_c),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign fifo_word    = fifo_rd;
    assign pop_c        = enable && (phase == '0) && !fifo_empty;
    assign pop_marker_c = pop_c && is_marker(fifo_word);
    // A data word entering the shift registers (from SYNC or a RUN reload).
    assign load_c       = pop_c && !pop_marker_c && ((state == SYNC) || (state == RUN));

    // Bit to emit next cycle: the new word's MSB on a load, else the register MSB.
    assign i_bit_c = load_c ? fifo_word.i[15] : i_sr[15];
    assign q_bit_c = load_c ? fifo_word.q[15] : q_sr[15];

`ifdef FAST_SQUARE_TX_SHAPE_EN
    logic i_prev;
    logic q_prev;
    logic entering_c;

    // On entry to RUN there is no previous bit; treat it as equal to the current one.
    assign entering_c = (state == SYNC);
    assign i_level_c  = (nrz_level(i_bit_c, AMPLITUDE) >>> 1)
                      + (nrz_level(entering_c ? i_bit_c : i_prev, AMPLITUDE) >>> 1);
    assign q_level_c  = (nrz_level(q_bit_c, AMPLITUDE) >>> 1)
                      + (nrz_level(entering_c ? q_bit_c : q_prev, AMPLITUDE) >>> 1);

    // Last bit handed to the output stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_prev <= 1'b0;
            q_prev <= 1'b0;
        end else begin
            i_prev <= i_bit_c;
            q_prev <= q_bit_c;
        end
    end
`else
    assign i_level_c = nrz_level(i_bit_c, AMPLITUDE);
    assign q_level_c = nrz_level(q_bit_c, AMPLITUDE);
`endif

    // Control FSM, phase counter, shift registers and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            marker_cnt <= '0;
            i_sr       <= '0;
            q_sr       <= '0;
            data_req   <= 1'b0;
            i_out      <= '0;
            q_out      <= '0;
            tx_active  <= 1'b0;
            underrun   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            data_req  <= pop_c;
            phase     <= enable ? phase + PHASE_W'(1) : '0;
            i_out     <= '0;
            q_out     <= '0;
            tx_active <= 1'b0;
            if (data_in_strobe && fifo_full) overflow <= 1'b1;

            if (!enable) begin
                state      <= IDLE;
                marker_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop_marker_c) begin
                            marker_cnt <= marker_cnt + MCNT_W'(1);
                            if (marker_cnt + MCNT_W'(1) >= MCNT_MAX) state <= SYNC;
                        end else if (pop_c) begin
                            marker_cnt <= '0;
                        end
                    end
                    SYNC: begin
                        if (load_c) state <= RUN;
                    end
                    RUN: begin
                        if ((phase == '0) && fifo_empty) begin
                            underrun   <= 1'b1;
                            state      <= IDLE;
                            marker_cnt <= '0;
                        end else if (pop_marker_c) begin
                            state      <= SYNC;
                            marker_cnt <= MCNT_MAX;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        marker_cnt <= '0;
                    end
                endcase

                // Emit a sample on a load or on any non-boundary RUN cycle.
                if (load_c || ((state == RUN) && (phase != '0))) begin
                    i_out     <= i_level_c;
                    q_out     <= q_level_c;
                    tx_active <= 1'b1;
                    i_sr      <= load_c ? {fifo_word.i[14:0], 1'b0} : {i_sr[14:0], 1'b0};
                    q_sr      <= load_c ? {fifo_word.q[14:0], 1'b0} : {q_sr[14:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_fast_square_tx_bb.sv
// tb_fast_square_tx_bb: randomized and directed stimulus for fast_square_tx_bb,
// checked every cycle against a queue-based behavioural model, plus literal
// expectations for the directed scenarios.
module tb_fast_square_tx_bb;

    localparam int DEPTH  = 4;
    localparam int MIN_MK = 8;
    localparam int AMP    = 8192;
    localparam logic [15:0] MK = 16'h8000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic data_in_strobe = 1'b0;
    logic [15:0] i_in = '0;
    logic [15:0] q_in = '0;
    logic fifo_full, data_req, tx_active, underrun, overflow;
    logic signed [15:0] i_out, q_out;

    always #5 clock = ~clock;

    fast_square_tx_bb dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .data_in_strobe (data_in_strobe),
        .i_in           (i_in),
        .q_in           (q_in),
        .fifo_full      (fifo_full),
        .data_req       (data_req),
        .i_out          (i_out),
        .q_out          (q_out),
        .tx_active      (tx_active),
        .underrun       (underrun),
        .overflow       (overflow)
    );

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_fifo[$];
    bit          pend_i[$];
    bit          pend_q[$];
    int          m_phase, m_state, m_mk;   // m_state: 0 idle, 1 sync, 2 run
    int          e_i, e_q;
    bit          e_act, e_req, e_und, e_ovf, e_full;
    bit          valid = 0;
`ifdef FAST_SQUARE_TX_SHAPE_EN
    bit          m_last_i, m_last_q;
`endif

    always @(posedge clock) begin : model
        logic [31:0] w;
        bit full_now, do_pop, ci, cq;
`ifdef FAST_SQUARE_TX_SHAPE_EN
        bit fresh, pi, pq;
        fresh = 0;
`endif
        w = '0;
        if (reset) begin
            m_fifo.delete(); pend_i.delete(); pend_q.delete();
            m_phase = 0; m_state = 0; m_mk = 0;
            e_i = 0; e_q = 0; e_act = 0; e_req = 0; e_und = 0; e_ovf = 0; e_full = 0;
            valid = 1;
        end else begin
            full_now = (m_fifo.size() == DEPTH);
            do_pop   = enable && (m_phase == 0) && (m_fifo.size() != 0);
            if (do_pop) w = m_fifo.pop_front();
            if (data_in_strobe) begin
                if (full_now) e_ovf = 1;
                else m_fifo.push_back({i_in, q_in});
            end
            e_req = do_pop;
            if (!enable) begin
                m_state = 0; m_mk = 0; pend_i.delete(); pend_q.delete();
            end else if (do_pop) begin
                if (w == {MK, MK}) begin
                    if (m_state == 2) begin
                        m_state = 1; m_mk = MIN_MK; pend_i.delete(); pend_q.delete();
                    end else if (m_state == 0) begin
                        m_mk++;
                        if (m_mk >= MIN_MK) begin m_mk = MIN_MK; m_state = 1; end
                    end
                end else if (m_state == 0) begin
                    m_mk = 0;
                end else begin
`ifdef FAST_SQUARE_TX_SHAPE_EN
                    fresh = (m_state == 1);
`endif
                    m_state = 2;
                    for (int k = 31; k >= 16; k--) pend_i.push_back(w[k]);
                    for (int k = 15; k >= 0; k--)  pend_q.push_back(w[k]);
                end
            end else if (m_phase == 0 && m_state == 2) begin
                e_und = 1; m_state = 0; m_mk = 0;
            end
            if (m_state == 2 && pend_i.size() != 0) begin
                ci = pend_i.pop_front();
                cq = pend_q.pop_front();
`ifdef FAST_SQUARE_TX_SHAPE_EN
                pi = fresh ? ci : m_last_i;
                pq = fresh ? cq : m_last_q;
                e_i = (ci ? AMP / 2 : -AMP / 2) + (pi ? AMP / 2 : -AMP / 2);
                e_q = (cq ? AMP / 2 : -AMP / 2) + (pq ? AMP / 2 : -AMP / 2);
                m_last_i = ci; m_last_q = cq;
`else
                e_i = ci ? AMP : -AMP;
                e_q = cq ? AMP : -AMP;
`endif
                e_act = 1;
            end else begin
                e_i = 0; e_q = 0; e_act = 0;
            end
            m_phase = enable ? (m_phase + 1) % 16 : 0;
            e_full  = (m_fifo.size() == DEPTH);
        end
    end

    // ---------------- per-cycle compare + capture ----------------
    int cap_n = 0;
    int req_n = 0;
    int cap_i[64];
    int cap_q[64];

    always @(negedge clock) begin
        if (valid) begin
            chk("i_out", i_out, e_i);
            chk("q_out", q_out, e_q);
            chk("tx_active", tx_active, e_act);
            chk("data_req", data_req, e_req);
            chk("underrun", underrun, e_und);
            chk("overflow", overflow, e_ovf);
            chk("fifo_full", fifo_full, e_full);
            if (tx_active) begin
                if (cap_n < 64) begin
                    cap_i[cap_n] = i_out;
                    cap_q[cap_n] = q_out;
                end
                cap_n++;
            end
            if (data_req) req_n++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; data_in_strobe = 1'b0; i_in = '0; q_in = '0;
        tick(3);
        reset = 1'b0;
        tick(1);
        cap_n = 0; req_n = 0;
    endtask

    task automatic push(input logic [15:0] wi, input logic [15:0] wq);
        int waited;
        waited = 0;
        while (fifo_full && waited < 400) begin tick(1); waited++; end
        if (fifo_full) chk("push_wait_timeout", 1, 0);
        data_in_strobe = 1'b1; i_in = wi; q_in = wq;
        tick(1);
        data_in_strobe = 1'b0;
    endtask

    task automatic push_markers(input int n);
        for (int k = 0; k < n; k++) push(MK, MK);
    endtask

    task automatic wait_underrun(input int budget);
        int n;
        n = 0;
        while (!underrun && n < budget) begin tick(1); n++; end
        chk("underrun_seen", underrun, 1);
        tick(2);
    endtask

    logic [15:0] word_a;
    int shape_exp[16] = '{8192, 8192, 8192, 8192, 0, -8192, -8192, -8192,
                          0, 8192, 8192, 8192, 0, -8192, -8192, -8192};

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset state.
        do_reset();
        chk("rst_i_out", i_out, 0);
        chk("rst_tx_active", tx_active, 0);
        chk("rst_fifo_full", fifo_full, 0);

        // 1: sync on 8 markers, one data word, then underrun.
        enable = 1'b1;
        push_markers(MIN_MK);
        push(16'hA5A5, 16'hFFFF);
        wait_underrun(300);
        chk("t1_active_cycles", cap_n, 16);
`ifndef FAST_SQUARE_TX_SHAPE_EN
        word_a = 16'hA5A5;
        for (int k = 0; k < 16; k++) begin
            chk("t1_i_sample", cap_i[k], word_a[15-k] ? 8192 : -8192);
            chk("t1_q_sample", cap_q[k], 8192);
        end
`endif
        chk("t1_i_after", i_out, 0);
        chk("t1_tx_active_after", tx_active, 0);

        // 2: only 7 markers, data word discarded.
        do_reset();
        enable = 1'b1;
        push_markers(MIN_MK - 1);
        push(16'h1234, 16'h5678);
        tick(100);
        chk("t2_data_req_pulses", req_n, 8);
        chk("t2_active_cycles", cap_n, 0);
        chk("t2_underrun", underrun, 0);

        // 3: three back-to-back data words, 48 gapless samples.
        do_reset();
        enable = 1'b1;
        push_markers(MIN_MK);
        for (int k = 0; k < 3; k++) push(16'($urandom), 16'($urandom));
        wait_underrun(300);
        chk("t3_active_cycles", cap_n, 48);

        // 4: marker mid-stream re-enters SYNC; next data resumes directly.
        do_reset();
        enable = 1'b1;
        push_markers(MIN_MK);
        push(16'h0F0F, 16'h3C3C);
        push(MK, MK);
        push(16'hC001, 16'h7FFE);
        wait_underrun(300);
        chk("t4_active_cycles", cap_n, 32);
        chk("t4_data_req_pulses", req_n, 11);

        // 5: five writes with enable low; fifth is dropped.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            data_in_strobe = 1'b1;
            i_in = (k < 4) ? MK : 16'h1357;
            q_in = (k < 4) ? MK : 16'h2468;
            tick(1);
            if (k == 3) begin
                chk("t5_full_after_4", fifo_full, 1);
                chk("t5_no_overflow_yet", overflow, 0);
            end
        end
        data_in_strobe = 1'b0;
        chk("t5_overflow", overflow, 1);
        enable = 1'b1;
        push_markers(4);
        push(16'hF00F, 16'h0FF0);
        wait_underrun(300);
        chk("t5_active_cycles", cap_n, 16);
        chk("t5_overflow_sticky", overflow, 1);

`ifdef FAST_SQUARE_TX_SHAPE_EN
        // Shaped output of two 0xF0F0 words.
        do_reset();
        enable = 1'b1;
        push_markers(MIN_MK);
        push(16'hF0F0, 16'hFFFF);
        push(16'hF0F0, 16'hFFFF);
        wait_underrun(300);
        chk("shape_active_cycles", cap_n, 32);
        for (int k = 0; k < 32; k++) begin
            chk("shape_i_sample", cap_i[k], (k == 16) ? 0 : shape_exp[k % 16]);
            chk("shape_q_sample", cap_q[k], 8192);
        end
`endif

        // 6: randomized traffic with markers, gaps, enable drops, forced overflows.
        do_reset();
        enable = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push_markers(MIN_MK);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(0, 99) < 12) push(MK, MK);
                else push(16'($urandom), 16'($urandom));
                tick($urandom_range(0, 18));
                if ($urandom_range(0, 29) == 0) begin
                    enable = 1'b0;
                    tick($urandom_range(1, 20));
                    enable = 1'b1;
                end
                if ($urandom_range(0, 24) == 0) begin
                    data_in_strobe = 1'b1;
                    i_in = 16'($urandom); q_in = 16'($urandom);
                    tick(1);
                    data_in_strobe = 1'b0;
                end
            end
            tick(100);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
